// File: rtl/psum_pkg.sv
// Shared definitions for the psum accumulate/drain controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psum_pkg;

  localparam int PSUM_PDATA_W = 16;
  localparam int PSUM_ADDR_W  = 8;
  localparam int PSUM_LEN_W   = 9;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_FLUSH = 2'd1,
    ACC_DRAIN = 2'd2
  } acc_state_t;

endpackage

// File: rtl/psum_skid_fifo.sv
// Two-entry FIFO holding drained psum words between memory read data and the output port.
// Latency: a push is visible at o_head the cycle after it is written (registered storage).
// Backpressure: none internally; the producer must not push when full unless it pops that cycle.
// Ports: i_push/i_push_data write, i_pop removes the head, o_count/o_empty occupancy, o_head data.
module psum_skid_fifo
  import psum_pkg::*;
#(
  parameter int W = PSUM_PDATA_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head,
  output logic         o_empty
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_eff;

  // A pop on an empty FIFO is meaningless; ignore it rather than underflow.
  assign pop_eff = i_pop && (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({i_push, pop_eff})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = i_push_data;
          cnt_d  = 2'd1;
        end else if (cnt_q == 2'd1) begin
          tail_d = i_push_data;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; with one entry the new word becomes the head directly.
        if (cnt_q == 2'd1) begin
          head_d = i_push_data;
        end else begin
          head_d = tail_q;
          tail_d = i_push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_count = cnt_q;
  assign o_head  = head_q;
  assign o_empty = (cnt_q == 2'd0);

endmodule

// File: rtl/psum_acc_ctrl.sv
// Psum memory initiator: read-modify-write accumulation of partial sums, and range drain to a stream.
// Latency: accumulate writes memory 1 cycle after acceptance; drain output starts 4 cycles after start.
// Backpressure: o_in_ready low outside IDLE; drain reads throttle on i_out_ready via a 2-entry FIFO.
// Ports: i_in_* accumulate request, i_drain_* drain command, o_out_* drain stream,
//        o_mem_wr_* / o_mem_rd_* / i_mem_rd_data synchronous memory, o_busy / o_done status.
module psum_acc_ctrl
  import psum_pkg::*;
#(
  parameter int PDATA_WIDTH = PSUM_PDATA_W,
  parameter int ADDR_WIDTH  = PSUM_ADDR_W,
  parameter int LEN_WIDTH   = PSUM_LEN_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [ADDR_WIDTH-1:0]  i_in_addr,
  input  logic [PDATA_WIDTH-1:0] i_in_data,
  input  logic                   i_in_first,
  input  logic                   i_drain_start,
  input  logic [ADDR_WIDTH-1:0]  i_drain_base,
  input  logic [LEN_WIDTH-1:0]   i_drain_len,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [PDATA_WIDTH-1:0] o_out_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  o_mem_wr_addr,
  output logic [PDATA_WIDTH-1:0] o_mem_wr_data,
  output logic                   o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_mem_rd_addr,
  input  logic [PDATA_WIDTH-1:0] i_mem_rd_data
);

  acc_state_t             state_q, state_d;

  logic                   s1_vld_q, s1_vld_d;
  logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
  logic [PDATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                   s1_first_q, s1_first_d;

  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]   rd_left_q, rd_left_d;
  logic [LEN_WIDTH-1:0]   out_left_q, out_left_d;
  logic                   rd_pend_q;

  logic                   in_fire;
  logic                   acc_rd;
  logic                   drain_rd;
  logic                   out_pop;
  logic [1:0]             fifo_cnt;
  logic                   fifo_empty;
  logic [PDATA_WIDTH-1:0] fifo_head;
  logic [2:0]             occ;

  // A start pulse steals the cycle from a coincident accumulate request.
  assign o_in_ready = (state_q == ACC_IDLE) && !i_drain_start;
  assign in_fire    = i_in_valid && o_in_ready;
  assign acc_rd     = in_fire && !i_in_first;

  // ---------------- accumulate stage ----------------
  always_comb begin
    s1_vld_d   = in_fire;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    s1_first_d = s1_first_q;
    if (in_fire) begin
      s1_addr_d  = i_in_addr;
      s1_data_d  = i_in_data;
      s1_first_d = i_in_first;
    end
  end

  // The read for an op is issued in its accept cycle and its data arrives now; a same-address
  // op one cycle later reads after this write has landed, so no forwarding path is needed.
  assign o_mem_wr_en   = s1_vld_q;
  assign o_mem_wr_addr = s1_vld_q ? s1_addr_q : '0;
  assign o_mem_wr_data = !s1_vld_q  ? '0 :
                         s1_first_q ? s1_data_q :
                                      i_mem_rd_data + s1_data_q;

  // ---------------- drain read issue ----------------
  assign out_pop = o_out_valid && i_out_ready;

  // Words owed to the FIFO after this cycle: stored + arriving - leaving. Counting this
  // cycle's pop keeps one read per cycle flowing when the sink never stalls.
  assign occ = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, out_pop};

  assign drain_rd = (state_q == ACC_DRAIN) && (rd_left_q != '0) && (occ < 3'd2);

  assign o_mem_rd_en   = acc_rd || drain_rd;
  assign o_mem_rd_addr = acc_rd   ? i_in_addr :
                         drain_rd ? rd_ptr_q  : '0;

  psum_skid_fifo #(
    .W (PDATA_WIDTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (rd_pend_q),
    .i_push_data (i_mem_rd_data),
    .i_pop       (out_pop),
    .o_count     (fifo_cnt),
    .o_head      (fifo_head),
    .o_empty     (fifo_empty)
  );

  assign o_out_valid = !fifo_empty;
  assign o_out_data  = fifo_head;
  assign o_busy      = (state_q != ACC_IDLE);

  // ---------------- control FSM ----------------
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    o_done     = 1'b0;
    case (state_q)
      ACC_IDLE: begin
        if (i_drain_start) begin
          state_d    = ACC_FLUSH;
          rd_ptr_d   = i_drain_base;
          rd_left_d  = i_drain_len;
          out_left_d = i_drain_len;
        end
      end
      ACC_FLUSH: begin
        // Drain reads must not overtake a write still sitting in the accumulate stage.
        if (!s1_vld_q) begin
          if (out_left_q == '0) begin
            state_d = ACC_IDLE;
            o_done  = 1'b1;
          end else begin
            state_d = ACC_DRAIN;
          end
        end
      end
      ACC_DRAIN: begin
        if (drain_rd) begin
          rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
          rd_left_d = rd_left_q - LEN_WIDTH'(1);
        end
        if (out_pop) begin
          out_left_d = out_left_q - LEN_WIDTH'(1);
          if (out_left_q == LEN_WIDTH'(1)) begin
            state_d = ACC_IDLE;
            o_done  = 1'b1;
          end
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ACC_IDLE;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_first_q <= 1'b0;
      rd_ptr_q   <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_first_q <= s1_first_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      rd_pend_q  <= drain_rd;
    end
  end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
module tb_psum_acc_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [7:0]  i_in_addr;
  logic [15:0] i_in_data;
  logic        i_in_first;
  logic        i_drain_start;
  logic [7:0]  i_drain_base;
  logic [8:0]  i_drain_len;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_out_data;
  logic        o_busy;
  logic        o_done;
  logic        o_mem_wr_en;
  logic [7:0]  o_mem_wr_addr;
  logic [15:0] o_mem_wr_data;
  logic        o_mem_rd_en;
  logic [7:0]  o_mem_rd_addr;
  logic [15:0] i_mem_rd_data;

  psum_acc_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_addr     (i_in_addr),
    .i_in_data     (i_in_data),
    .i_in_first    (i_in_first),
    .i_drain_start (i_drain_start),
    .i_drain_base  (i_drain_base),
    .i_drain_len   (i_drain_len),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Synchronous psum memory: address latched at the edge, data valid the next cycle, junk otherwise.
  logic [15:0] mem [256] = '{default: '0};
  logic        rdv_q  = 1'b0;
  logic [7:0]  rda_q  = '0;
  logic [15:0] junk_q = '0;
  always @(posedge i_clk) begin
    if (o_mem_wr_en) mem[o_mem_wr_addr] <= o_mem_wr_data;
    rdv_q  <= o_mem_rd_en;
    rda_q  <= o_mem_rd_addr;
    junk_q <= 16'($urandom);
  end
  assign i_mem_rd_data = rdv_q ? mem[rda_q] : junk_q;

  // Reference model state.
  logic [15:0] ref_mem [256] = '{default: '0};
  logic [15:0] exp_q[$];
  logic [15:0] out_log[$];
  int          out_cyc[$];
  logic [7:0]  rdaddr_log[$];
  bit          busy_m;
  int          len_m, rd_issued, popped, done_cnt, done_cyc, cyc;
  logic [7:0]  nxt_rd;
  int          total, bad;
  int          rdy_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int mem_mismatch();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Per-cycle compare against the behavioural model.
  initial begin
    busy_m = 0; done_cnt = 0; cyc = 0; len_m = 0; rd_issued = 0; popped = 0; nxt_rd = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        busy_m = 0;
        exp_q.delete();
      end else begin
        bit was_busy, exp_rdy, done_exp;
        was_busy = busy_m;
        exp_rdy  = !was_busy && !i_drain_start;
        done_exp = 0;
        chk("in_ready", o_in_ready, exp_rdy);
        chk("busy", o_busy, was_busy);
        if (was_busy) chk("wr_idle_in_drain", o_mem_wr_en, 0);
        if (exp_rdy && i_in_valid) begin
          chk("acc_rd_en", o_mem_rd_en, !i_in_first);
          if (!i_in_first) chk("acc_rd_addr", o_mem_rd_addr, i_in_addr);
          ref_mem[i_in_addr] = i_in_first ? i_in_data : 16'(ref_mem[i_in_addr] + i_in_data);
        end else if (!was_busy) begin
          chk("rd_quiet", o_mem_rd_en, 0);
        end else if (o_mem_rd_en) begin
          chk("drain_rd_addr", o_mem_rd_addr, nxt_rd);
          rdaddr_log.push_back(o_mem_rd_addr);
          nxt_rd++;
          rd_issued++;
          chk("drain_rd_count", rd_issued <= len_m, 1);
        end
        if (o_out_valid && i_out_ready) begin
          if (!was_busy || exp_q.size() == 0) begin
            chk("unexpected_out", o_out_valid, 0);
          end else begin
            chk("out_data", o_out_data, exp_q.pop_front());
            out_log.push_back(o_out_data);
            out_cyc.push_back(cyc);
            popped++;
            if (exp_q.size() == 0) done_exp = 1;
          end
        end
        if (!was_busy) chk("out_valid_idle", o_out_valid, 0);
        if (was_busy) chk("outstanding_le2", (rd_issued - popped) <= 2, 1);
        if (was_busy && len_m == 0) done_exp = 1;
        chk("done", o_done, done_exp);
        if (done_exp) begin
          busy_m = 0;
          done_cnt++;
          done_cyc = cyc;
          chk("mem_image_at_done", mem_mismatch(), 0);
        end
        if (!was_busy && i_drain_start) begin
          busy_m    = 1;
          len_m     = int'(i_drain_len);
          nxt_rd    = i_drain_base;
          rd_issued = 0;
          popped    = 0;
          exp_q.delete();
          for (int i = 0; i < len_m; i++) exp_q.push_back(ref_mem[8'(int'(i_drain_base) + i)]);
        end
      end
    end
  end

  // Downstream ready: always, 1-0-0 pattern, or random.
  initial begin
    int ph;
    ph = 0;
    i_out_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (ph % 3 == 0);
        default: i_out_ready = ($urandom % 3 != 0);
      endcase
      ph++;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [15:0] d, input logic f);
    i_in_valid = 1'b1; i_in_addr = a; i_in_data = d; i_in_first = f;
  endtask

  task automatic idle_in();
    i_in_valid = 1'b0; i_in_addr = '0; i_in_data = '0; i_in_first = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_done_seen", done_cnt - d0, 1);
  endtask

  task automatic drain(input logic [7:0] b, input logic [8:0] l);
    int d0;
    d0 = done_cnt;
    out_log.delete(); out_cyc.delete(); rdaddr_log.delete();
    i_drain_start = 1'b1; i_drain_base = b; i_drain_len = l;
    step();
    i_drain_start = 1'b0;
    wait_done(d0);
  endtask

  initial begin
    logic [15:0] vals [8];
    int d0, n;
    total = 0; bad = 0; rdy_mode = 0;
    i_rst = 1'b1; idle_in();
    i_drain_start = 1'b0; i_drain_base = '0; i_drain_len = '0;
    repeat (2) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_wr_en", o_mem_wr_en, 0);
    chk("rst_rd_en", o_mem_rd_en, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_wr_data", o_mem_wr_data, 0);
    i_rst = 1'b0;
    step();

    // Overwrite then back-to-back accumulate on one address.
    drive(8'd3, 16'd5, 1'b1); step();
    drive(8'd3, 16'd7, 1'b0); step();
    drive(8'd3, 16'hFFFE, 1'b0); step();
    idle_in(); step(); step();
    chk("t1_mem3", mem[3], 16'd10);

    // Two's-complement wrap.
    drive(8'd9, 16'h7FFF, 1'b1); step();
    drive(8'd9, 16'd1, 1'b0); step();
    idle_in(); step(); step();
    chk("t2_mem9", mem[9], 16'h8000);

    // Full-rate drain of {1,2,3,4}.
    for (int i = 0; i < 4; i++) begin drive(8'(i), 16'(i + 1), 1'b1); step(); end
    idle_in(); step();
    drain(8'd0, 9'd4);
    chk("t3_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_data", out_log[i], 32'(i + 1));
      chk("t3_back_to_back", out_cyc[3] - out_cyc[0], 3);
      chk("t3_done_on_last", done_cyc, out_cyc[3]);
    end

    // Drain under 1-0-0 ready pattern.
    for (int i = 0; i < 8; i++) begin
      vals[i] = 16'($urandom);
      drive(8'(40 + i), vals[i], 1'b1); step();
    end
    idle_in(); step();
    rdy_mode = 1;
    drain(8'd40, 9'd8);
    rdy_mode = 0;
    chk("t4_count", out_log.size(), 8);
    if (out_log.size() == 8) for (int i = 0; i < 8; i++) chk("t4_data", out_log[i], vals[i]);

    // Start coincident with an input while a stage-1 op is pending.
    drive(8'd20, 16'd40, 1'b1); step();
    drive(8'd20, 16'd3, 1'b0); step();
    d0 = done_cnt;
    out_log.delete(); out_cyc.delete();
    drive(8'd20, 16'd100, 1'b0);
    i_drain_start = 1'b1; i_drain_base = 8'd20; i_drain_len = 9'd1;
    step();
    i_drain_start = 1'b0; idle_in();
    wait_done(d0);
    chk("t5_count", out_log.size(), 1);
    if (out_log.size() == 1) chk("t5_data", out_log[0], 16'd43);
    chk("t5_mem20", mem[20], 16'd43);

    // Address wrap during drain, then zero-length drain.
    drain(8'd254, 9'd4);
    chk("t6_rd_count", rdaddr_log.size(), 4);
    if (rdaddr_log.size() == 4) begin
      chk("t6_addr0", rdaddr_log[0], 8'd254);
      chk("t6_addr1", rdaddr_log[1], 8'd255);
      chk("t6_addr2", rdaddr_log[2], 8'd0);
      chk("t6_addr3", rdaddr_log[3], 8'd1);
    end
    drain(8'd5, 9'd0);
    chk("t6_len0_no_out", out_log.size(), 0);

    // Reset in the middle of a drain.
    d0 = done_cnt;
    i_drain_start = 1'b1; i_drain_base = 8'd0; i_drain_len = 9'd10;
    step();
    i_drain_start = 1'b0;
    repeat (5) step();
    chk("pre_rst_busy", o_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_out_valid", o_out_valid, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_rd_en", o_mem_rd_en, 0);
    chk("midrst_wr_en", o_mem_wr_en, 0);
    chk("midrst_out_data", o_out_data, 0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    step();
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_ready", o_in_ready, 1);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("post_rst_mem", mem_mismatch(), 0);

    // Randomized traffic: accumulates, drains, ignored starts, random backpressure.
    rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      int a;
      a = $urandom_range(0, 13);
      if (a > 7) a = a + 242;
      i_in_valid = ($urandom % 4 != 0);
      i_in_addr  = 8'(a);
      i_in_data  = 16'($urandom);
      i_in_first = ($urandom % 4 == 0);
      i_drain_start = ($urandom % 16 == 0);
      a = $urandom_range(0, 13);
      if (a > 7) a = a + 242;
      i_drain_base = 8'(a);
      i_drain_len  = 9'($urandom_range(0, 12));
      step();
    end
    idle_in();
    i_drain_start = 1'b0;
    n = 0;
    while (busy_m && n < 300) begin
      step();
      n++;
    end
    chk("final_idle", busy_m, 0);
    step(); step();
    chk("final_mem_image", mem_mismatch(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
